// File: rtl/accel_poll_sequencer_pkg.sv
// Shared register map, state encoding and transfer counts for the accelerometer poll sequencer.
package accel_poll_sequencer_pkg;

    localparam logic [5:0] REG_BW_RATE     = 6'h2C;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_DATAX0      = 6'h32;

    localparam int NUM_CFG  = 3;
    localparam int NUM_DATA = 6;

    localparam logic [2:0] ST_CFG_ISSUE = 3'd0;
    localparam logic [2:0] ST_CFG_WAIT  = 3'd1;
    localparam logic [2:0] ST_WAIT_TICK = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT   = 3'd4;
    localparam logic [2:0] ST_PUBLISH   = 3'd5;

    // Configuration write order: data rate, data format, then measure mode last.
    function automatic logic [5:0] cfg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_addr = REG_BW_RATE;
            2'd1:    cfg_addr = REG_DATA_FORMAT;
            default: cfg_addr = REG_POWER_CTL;
        endcase
    endfunction

endpackage

// File: rtl/accel_poll_sequencer_if.sv
// Command/response signals between the poll sequencer and the SPI master.
interface accel_poll_sequencer_if;
    logic       spi_start;
    logic       spi_rw;
    logic [5:0] spi_addr;
    logic [7:0] spi_wdata;
    logic       spi_busy;
    logic       spi_done;
    logic [7:0] spi_rdata;

    modport master (
        output spi_start, spi_rw, spi_addr, spi_wdata,
        input  spi_busy, spi_done, spi_rdata
    );

    modport slave (
        input  spi_start, spi_rw, spi_addr, spi_wdata,
        output spi_busy, spi_done, spi_rdata
    );
endinterface

// File: rtl/accel_tick_gen.sv
// Free-running divider: counts 0..SAMPLE_DIV-1 and emits a one-cycle tick on the wrap cycle.
module accel_tick_gen #(
    parameter int SAMPLE_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/accel_poll_sequencer.sv
// Configures the SPI accelerometer once, then polls its six data registers on every tick
// and publishes signed X/Y/Z samples; a per-transfer watchdog forces reconfiguration.
module accel_poll_sequencer
    import accel_poll_sequencer_pkg::*;
#(
    parameter int         SAMPLE_DIV  = 500000,
    parameter int         TIMEOUT     = 4096,
    parameter logic [7:0] BW_RATE_VAL = 8'h0A,
    parameter logic [7:0] FORMAT_VAL  = 8'h0B,
    parameter logic [7:0] POWER_VAL   = 8'h08
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   err_clr,
    accel_poll_sequencer_if.master spi,
    output logic signed [15:0]     accel_x,
    output logic signed [15:0]     accel_y,
    output logic signed [15:0]     accel_z,
    output logic                   sample_valid,
    output logic                   cfg_done,
    output logic                   err_timeout,
    output logic                   err_overrun
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam int SH_W = 8 * (NUM_DATA - 1);

    logic [2:0]          state;
    logic [1:0]          cfg_idx;
    logic [2:0]          byte_idx;
    logic [WD_W-1:0]     wd_cnt;
    logic [SH_W-1:0]     shadow;
    logic [SH_W+7:0]     sample_word;
    logic                tick;
    logic                in_wait;
    logic                in_poll;
    logic                to_evt;
    logic                ovr_evt;
    logic                last_cfg;
    logic                last_byte;

    function automatic logic [7:0] cfg_wdata(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_wdata = BW_RATE_VAL;
            2'd1:    cfg_wdata = FORMAT_VAL;
            default: cfg_wdata = POWER_VAL;
        endcase
    endfunction

    accel_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign in_wait      = (state == ST_CFG_WAIT) || (state == ST_RD_WAIT);
    assign in_poll      = (state == ST_RD_ISSUE) || (state == ST_RD_WAIT) || (state == ST_PUBLISH);
    assign to_evt       = in_wait && !spi.spi_done && (wd_cnt == WD_LAST);
    assign ovr_evt      = tick && in_poll;
    assign last_cfg     = (cfg_idx == 2'(NUM_CFG - 1));
    assign last_byte    = (byte_idx == 3'(NUM_DATA - 1));
    assign sample_valid = (state == ST_PUBLISH);
    // The final byte is taken straight from the bus so all three axes update in one edge.
    assign sample_word  = {spi.spi_rdata, shadow};

    always_ff @(posedge clk) begin
        if (state == ST_RD_WAIT && spi.spi_done && !last_byte)
            shadow[{byte_idx, 3'b000} +: 8] <= spi.spi_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_CFG_ISSUE;
            cfg_idx       <= '0;
            byte_idx      <= '0;
            wd_cnt        <= '0;
            spi.spi_start <= 1'b0;
            spi.spi_rw    <= 1'b0;
            spi.spi_addr  <= '0;
            spi.spi_wdata <= '0;
            accel_x       <= '0;
            accel_y       <= '0;
            accel_z       <= '0;
            cfg_done      <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            spi.spi_start <= 1'b0;

            // A new error event in the same cycle as err_clr keeps the flag set.
            if (ovr_evt)      err_overrun <= 1'b1;
            else if (err_clr) err_overrun <= 1'b0;
            if (to_evt)       err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;

            case (state)
                ST_CFG_ISSUE: begin
                    if (!spi.spi_busy) begin
                        spi.spi_start <= 1'b1;
                        spi.spi_rw    <= 1'b0;
                        spi.spi_addr  <= cfg_addr(cfg_idx);
                        spi.spi_wdata <= cfg_wdata(cfg_idx);
                        wd_cnt        <= '0;
                        state         <= ST_CFG_WAIT;
                    end
                end
                ST_CFG_WAIT: begin
                    if (spi.spi_done) begin
                        cfg_idx <= cfg_idx + 1'b1;
                        if (last_cfg) begin
                            cfg_done <= 1'b1;
                            state    <= ST_WAIT_TICK;
                        end else begin
                            state    <= ST_CFG_ISSUE;
                        end
                    end else if (to_evt) begin
                        cfg_done <= 1'b0;
                        cfg_idx  <= '0;
                        state    <= ST_CFG_ISSUE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_WAIT_TICK: begin
                    if (tick && enable) begin
                        byte_idx <= '0;
                        state    <= ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (!spi.spi_busy) begin
                        spi.spi_start <= 1'b1;
                        spi.spi_rw    <= 1'b1;
                        spi.spi_addr  <= REG_DATAX0 + {3'b000, byte_idx};
                        wd_cnt        <= '0;
                        state         <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (spi.spi_done) begin
                        byte_idx <= byte_idx + 1'b1;
                        if (last_byte) begin
                            accel_x <= $signed(sample_word[15:0]);
                            accel_y <= $signed(sample_word[31:16]);
                            accel_z <= $signed(sample_word[47:32]);
                            state   <= ST_PUBLISH;
                        end else begin
                            state   <= ST_RD_ISSUE;
                        end
                    end else if (to_evt) begin
                        cfg_done <= 1'b0;
                        cfg_idx  <= '0;
                        state    <= ST_CFG_ISSUE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_PUBLISH: state <= ST_WAIT_TICK;
                default:    state <= ST_CFG_ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Randomised bench for accel_poll_sequencer: behavioural SPI slave plus sample scoreboard.
module tb_accel_poll_sequencer;
    localparam int DIV  = 200;
    localparam int TMO  = 64;
    localparam int HANG = 80;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        int          c;
    } samp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic err_clr = 1'b0;
    logic signed [15:0] accel_x, accel_y, accel_z;
    logic sample_valid, cfg_done, err_timeout, err_overrun;

    accel_poll_sequencer_if spi_if();

    accel_poll_sequencer #(
        .SAMPLE_DIV (DIV),
        .TIMEOUT    (TMO),
        .BW_RATE_VAL(8'h0A),
        .FORMAT_VAL (8'h0B),
        .POWER_VAL  (8'h08)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .err_clr     (err_clr),
        .spi         (spi_if),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .accel_z     (accel_z),
        .sample_valid(sample_valid),
        .cfg_done    (cfg_done),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural SPI slave and expected-transaction model.
    logic [5:0] cfg_a [3] = '{6'h2C, 6'h31, 6'h2D};
    logic [7:0] cfg_d [3] = '{8'h0A, 8'h0B, 8'h08};
    samp_t      sb_q [$];
    logic [7:0] pb [6];
    int         cfg_i, rd_idx, wait_cnt, lat_lo, lat_hi, hang_start;
    bit         active, hanging, hold_arm, cfg_chk, en_h1, en_h2;
    logic [5:0] cur_addr;
    logic       cur_rw;

    initial begin
        logic [5:0] ea;
        logic [7:0] b;
        samp_t      e;
        spi_if.spi_busy = 1'b0;
        spi_if.spi_done = 1'b0;
        spi_if.spi_rdata = 8'h00;
        hold_arm = 0; hang_start = -1; cur_addr = '0; cur_rw = 1'b0;
        forever begin
            @(negedge clk);
            spi_if.spi_done = 1'b0;
            if (rst) begin
                spi_if.spi_busy = 1'b0;
                active = 0; hanging = 0; cfg_chk = 0;
                cfg_i = 0; rd_idx = 0; en_h1 = 0; en_h2 = 0;
            end else begin
                if (cfg_chk) begin
                    check("cfg_done_after_third_write", cfg_done, 1'b1);
                    cfg_chk = 0;
                end
                if (spi_if.spi_start) begin
                    check("start_while_busy", spi_if.spi_busy, 1'b0);
                    if (cfg_i < 3) begin
                        check("cfg_write", {spi_if.spi_rw, spi_if.spi_addr, spi_if.spi_wdata},
                              {1'b0, cfg_a[cfg_i], cfg_d[cfg_i]});
                    end else begin
                        ea = 6'h32 + 6'(rd_idx);
                        check("read_cmd", {spi_if.spi_rw, spi_if.spi_addr}, {1'b1, ea});
                        // A poll starts two cycles after an enabled tick; ticks fall on cyc%DIV == DIV-1.
                        if (rd_idx == 0)
                            check("poll_start_timing", {cyc % DIV == 1, cyc > DIV, en_h2}, 3'b111);
                    end
                    cur_addr = spi_if.spi_addr;
                    cur_rw   = spi_if.spi_rw;
                    spi_if.spi_busy = 1'b1;
                    active = 1;
                    if (hold_arm && cur_rw && cur_addr == 6'h34) begin
                        hold_arm = 0; hanging = 1; hang_start = cyc;
                        wait_cnt = HANG;
                        cfg_i = 0; rd_idx = 0;
                    end else begin
                        wait_cnt = $urandom_range(lat_hi, lat_lo);
                    end
                end else if (active) begin
                    wait_cnt--;
                    if (wait_cnt <= 0) begin
                        spi_if.spi_busy = 1'b0;
                        active = 0;
                        if (hanging) begin
                            hanging = 0;
                        end else if (!cur_rw) begin
                            spi_if.spi_done = 1'b1;
                            cfg_i++;
                            if (cfg_i == 3) cfg_chk = 1;
                        end else begin
                            b = 8'($urandom);
                            spi_if.spi_rdata = b;
                            spi_if.spi_done = 1'b1;
                            pb[rd_idx] = b;
                            rd_idx++;
                            if (rd_idx == 6) begin
                                e.x = {pb[1], pb[0]};
                                e.y = {pb[3], pb[2]};
                                e.z = {pb[5], pb[4]};
                                e.c = cyc;
                                sb_q.push_back(e);
                                rd_idx = 0;
                            end
                        end
                    end
                end
                en_h2 = en_h1;
                en_h1 = enable;
            end
        end
    end

    // Scoreboard monitor: pops on every sample_valid, otherwise outputs must hold.
    initial begin
        logic [47:0] held;
        samp_t       e;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = '0;
            end else if (sample_valid) begin
                check("sample_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sample_xyz", {accel_x, accel_y, accel_z}, {e.x, e.y, e.z});
                    check("sample_latency", cyc, e.c + 1);
                end
                held = {accel_x, accel_y, accel_z};
            end else begin
                check("accel_hold", {accel_x, accel_y, accel_z}, held);
            end
        end
    end

    task automatic wait_for(input int which, input int bound, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(posedge clk); #1;
            case (which)
                0: hit = cfg_done;
                1: hit = sample_valid;
                2: hit = spi_if.spi_busy && cur_rw && cur_addr == 6'h35;
                3: hit = spi_if.spi_busy && cur_rw && cur_addr == 6'h33;
                4: hit = (hang_start >= 0);
                default: hit = spi_if.spi_start;
            endcase
        end
        check(name, hit, 1'b1);
    endtask

    task automatic reset_check(input string name);
        check({name, "_ctrl"}, {spi_if.spi_start, spi_if.spi_rw, spi_if.spi_addr, spi_if.spi_wdata,
                                sample_valid, cfg_done, err_timeout, err_overrun}, '0);
        check({name, "_accel"}, {accel_x, accel_y, accel_z}, '0);
    endtask

    initial begin
        int s, n;
        rst = 1'b1; enable = 1'b1; err_clr = 1'b0;
        lat_lo = 20; lat_hi = 20;
        repeat (3) @(posedge clk);
        #1 reset_check("reset_state");
        rst = 1'b0;

        wait_for(0, 400, "cfg_done_rise");
        lat_lo = 2; lat_hi = 9;
        repeat (4 * DIV) @(posedge clk);
        #1 check("no_errors_normal", {err_timeout, err_overrun}, 2'b00);

        // Disable during the fourth read: that poll still publishes, then polling stops.
        wait_for(2, 2 * DIV, "byte3_read_seen");
        enable = 1'b0;
        wait_for(1, DIV, "disabled_poll_publishes");
        n = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(posedge clk); #1;
            if (spi_if.spi_start) n++;
        end
        check("no_start_while_disabled", n, 0);
        enable = 1'b1;
        wait_for(5, 2 * DIV + 5, "poll_resumed");

        // Slow SPI makes each poll outlast the tick period.
        lat_lo = 45; lat_hi = 45;
        repeat (3 * DIV) @(posedge clk);
        #1 check("overrun_set", err_overrun, 1'b1);
        lat_lo = 2; lat_hi = 9;
        wait_for(1, 2 * DIV, "slow_poll_finished");
        wait_for(1, 2 * DIV, "fast_poll_finished");
        check("overrun_sticky", err_overrun, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        check("overrun_cleared", err_overrun, 1'b0);

        // Withheld done on the third read triggers the watchdog.
        hang_start = -1; hold_arm = 1;
        wait_for(4, 2 * DIV, "hang_seen");
        if (hang_start >= 0) begin
            s = hang_start;
            for (int i = 0; i < 200 && cyc < s + TMO - 1; i++) @(negedge clk);
            check("timeout_not_early", err_timeout, 1'b0);
            @(negedge clk);
            check("timeout_at_limit", {cyc == s + TMO, err_timeout, cfg_done}, 3'b110);
        end
        wait_for(0, 3 * DIV, "cfg_redone_after_timeout");
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        check("errors_cleared", {err_timeout, err_overrun}, 2'b00);
        wait_for(1, 2 * DIV, "sample_after_timeout");

        // Asynchronous reset in the middle of a read.
        wait_for(3, 2 * DIV, "byte1_read_seen");
        rst = 1'b1;
        #1 reset_check("midrun_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_for(0, 400, "cfg_after_reset");
        wait_for(1, 2 * DIV, "sample_after_reset");
        #10 check("scoreboard_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/accel_poll_sequencer.md
Name: accel_poll_sequencer

Overview:
- Controller that sequences the SPI accelerometer master: configures the sensor once after reset, then polls the six axis registers at a fixed rate.
- Assembles each poll into signed 16-bit X/Y/Z samples and publishes them with a one-cycle valid strobe.
- Sits between the SPI master and downstream consumers (stabilisation loop, servo PWM position logic).
- Detects a hung SPI transaction (timeout) and re-runs configuration.

Parameters:
SAMPLE_DIV, 500000, clk cycles between poll starts (100 Hz at 50 MHz); legal range 64..2^24-1
TIMEOUT, 4096, max clk cycles from spi_start to spi_done before abort
BW_RATE_VAL, 8'h0A, value written to register 0x2C
FORMAT_VAL, 8'h0B, value written to register 0x31
POWER_VAL, 8'h08, value written to register 0x2D (measure mode)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-high reset
enable  in  1  polling allowed; sampled only in WAIT_TICK
err_clr  in  1  one-cycle pulse, clears sticky flags
spi_start  out  1  one-cycle request to SPI master
spi_rw  out  1  1=read, 0=write; valid with spi_start
spi_addr  out  6  register address; valid with spi_start
spi_wdata  out  8  write byte; valid with spi_start
spi_busy  in  1  SPI master mid-transaction
spi_done  in  1  one-cycle completion pulse
spi_rdata  in  8  read byte, valid on spi_done
accel_x / accel_y / accel_z  out  16 each  signed samples, {DATA1,DATA0}
sample_valid  out  1  one-cycle pulse, new X/Y/Z
cfg_done  out  1  high once configuration has succeeded
err_timeout  out  1  sticky timeout flag
err_overrun  out  1  sticky: tick arrived while a poll was still running

Behaviour:
- Reset (async assert, sync release): all outputs 0; state CFG_ISSUE; config index 0, byte index 0; tick counter 0.
- Tick counter free-runs 0..SAMPLE_DIV-1 and wraps. tick is high for one cycle at wrap.
- States:
  - CFG_ISSUE: wait for spi_busy=0. Then pulse spi_start with rw=0 and the addr/data pair for the current index: 0=(0x2C,BW_RATE_VAL), 1=(0x31,FORMAT_VAL), 2=(0x2D,POWER_VAL). Go to CFG_WAIT.
  - CFG_WAIT: on spi_done, increment the index. Index 3 sets cfg_done=1 and goes to WAIT_TICK; otherwise return to CFG_ISSUE.
  - WAIT_TICK: if tick && enable, clear byte index and go to RD_ISSUE.
  - RD_ISSUE: wait for spi_busy=0. Then pulse spi_start with rw=1, addr=0x32+byte index (0x32..0x37). Go to RD_WAIT.
  - RD_WAIT: on spi_done, latch spi_rdata into shadow byte[idx] and increment idx. idx 6 goes to PUBLISH; otherwise return to RD_ISSUE.
  - PUBLISH (one cycle): copy shadow to accel_x={b1,b0}, accel_y={b3,b2}, accel_z={b5,b4}. Assert sample_valid the same cycle. Go to WAIT_TICK.
- Latency: spi_start asserts exactly 1 cycle after entering an ISSUE state with spi_busy=0. sample_valid fires 1 cycle after the sixth spi_done.
- Outputs accel_* change only in PUBLISH; they are never partially updated.
- spi_start is never asserted while spi_busy=1 or while in a WAIT state.
- Timeout: in CFG_WAIT or RD_WAIT, a watchdog counts from spi_start. Reaching TIMEOUT with no spi_done:
  - set err_timeout and clear cfg_done;
  - discard the shadow bytes (no sample_valid);
  - return to CFG_ISSUE with index 0.
- A spi_done arriving in any state other than a WAIT state is ignored.
- Overrun: tick while in RD_ISSUE, RD_WAIT or PUBLISH sets err_overrun. The poll in progress completes; the missed tick is not queued.
- err_clr clears both sticky flags. If err_clr and a new error event occur in the same cycle, the set wins.
- enable=0 only stops new polls. A poll already in progress completes and publishes. Configuration runs regardless of enable.
- rst asserted mid-transaction aborts immediately. The SPI master is reset by the same rst.

Decomposition:
- Shared package: register address constants (0x2C, 0x31, 0x2D, 0x32); state enumeration; NUM_CFG=3, NUM_DATA=6.
- One sub-module is natural: accel_tick_gen (parameterised SAMPLE_DIV divider producing the one-cycle tick). It is reusable for the PWM update rate.

Test Plan:
1. Reset release, SPI model returns done after 20 cycles → exactly three writes in order (0x2C,0x0A), (0x31,0x0B), (0x2D,0x08); cfg_done=1 after the third done; no reads before the first tick.
2. SAMPLE_DIV=1000, model returns bytes 0x34,0x12,0xFE,0xFF,0x00,0x40 for addrs 0x32..0x37 → one sample_valid per 1000 cycles; accel_x=0x1234, accel_y=0xFFFE (-2), accel_z=0x4000.
3. Model withholds spi_done on the third read, TIMEOUT=64 → err_timeout=1 exactly 64 cycles after that spi_start; cfg_done=0; no sample_valid; config sequence restarts at 0x2C.
4. SAMPLE_DIV=64, model done latency 20 cycles (poll takes >64) → err_overrun=1; every published sample is complete; err_clr pulse clears the flag.
5. enable=0 during RD_WAIT of byte 3 → that sample still publishes; no further spi_start after it; re-asserting enable resumes at the next tick.
6. Assert rst during RD_WAIT → all outputs 0 immediately (async); after release, configuration restarts from index 0.
